// File: rtl/pipe_pkg.sv
// Shared MEM-stage types: FSM state encoding, datapath widths, small decode helper.
package pipe_pkg;
  localparam int DW         = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction
endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles spent waiting for a memory ack; expire is combinational on the last allowed cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Saturates at LAST so a non-power-of-two TIMEOUT never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = enable && (r_count == LAST);
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access, branch resolve, stall, MEM/WB register (ALU ops 1 cycle, loads ack+1).
// Stall holds EX/MEM for the whole transaction; optional MISALIGN_CHECK_EN rejects unaligned accesses.
module mem_access_stage #(
  parameter int DW      = pipe_pkg::DW,
  parameter int TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 BPC_in,
  input  logic [pipe_pkg::REG_ADDR_W-1:0] gprDes_in,
  input  logic [DW-1:0]                 aluOut_in,
  input  logic [DW-1:0]                 gprB_in,
  input  logic                          zero_in,
  input  logic                          pcSel_in,
  input  logic                          memR_in,
  input  logic                          memW_in,
  input  logic                          regW_in,
  input  logic                          memToR_in,
  output logic                          dm_req,
  output logic                          dm_we,
  output logic [DW-1:0]                 dm_addr,
  output logic [DW-1:0]                 dm_wdata,
  input  logic                          dm_ack,
  input  logic [DW-1:0]                 dm_rdata,
  output logic                          stall,
  output logic                          br_taken,
  output logic [DW-1:0]                 br_target,
  output logic                          wb_regW,
  output logic [pipe_pkg::REG_ADDR_W-1:0] wb_gprDes,
  output logic [DW-1:0]                 wb_data,
  output logic                          bus_err
`ifdef MISALIGN_CHECK_EN
  ,
  output logic                          misalign_err
`endif
);
  import pipe_pkg::state_t;
  import pipe_pkg::IDLE;
  import pipe_pkg::WAIT;
  import pipe_pkg::REG_ADDR_W;
  import pipe_pkg::is_mem_op;

  state_t                r_state;
  logic                  r_dm_req;
  logic                  r_dm_we;
  logic [DW-1:0]         r_dm_addr;
  logic [DW-1:0]         r_dm_wdata;
  logic                  r_wb_regW;
  logic [REG_ADDR_W-1:0] r_wb_gprDes;
  logic [DW-1:0]         r_wb_data;
  logic                  r_bus_err;

  logic w_mem_op;
  logic w_misalign;
  logic w_issue;
  logic w_expire;

  assign w_mem_op = is_mem_op(memR_in, memW_in);

`ifdef MISALIGN_CHECK_EN
  logic r_misalign_err;
  assign w_misalign   = w_mem_op && (aluOut_in[1:0] != 2'b00);
  assign misalign_err = r_misalign_err;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = w_mem_op && !w_misalign;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (r_state == IDLE),
    .enable (r_state == WAIT),
    .expire (w_expire)
  );

  // The held EX/MEM fields stay valid across WAIT, so write-back reads them at ack time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dm_req    <= 1'b0;
      r_dm_we     <= 1'b0;
      r_dm_addr   <= '0;
      r_dm_wdata  <= '0;
      r_wb_regW   <= 1'b0;
      r_wb_gprDes <= '0;
      r_wb_data   <= '0;
      r_bus_err   <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      r_misalign_err <= 1'b0;
`endif
    end else begin
      r_bus_err <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      r_misalign_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_dm_req   <= 1'b1;
            r_dm_we    <= memW_in;
            r_dm_addr  <= aluOut_in;
            r_dm_wdata <= gprB_in;
            r_wb_regW  <= 1'b0;
            r_state    <= WAIT;
          end else if (w_mem_op) begin
            r_wb_regW <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            r_misalign_err <= 1'b1;
`endif
          end else begin
            r_wb_regW   <= regW_in;
            r_wb_gprDes <= gprDes_in;
            r_wb_data   <= aluOut_in;
          end
        end
        WAIT: begin
          if (dm_ack) begin
            r_dm_req    <= 1'b0;
            r_wb_regW   <= regW_in && !memW_in;
            r_wb_gprDes <= gprDes_in;
            r_wb_data   <= memToR_in ? dm_rdata : aluOut_in;
            r_state     <= IDLE;
          end else if (w_expire) begin
            r_dm_req  <= 1'b0;
            r_wb_regW <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_wb_regW <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall     = (r_state == IDLE) ? w_issue : (!dm_ack && !w_expire);
  assign br_taken  = pcSel_in & zero_in;
  assign br_target = BPC_in;

  assign dm_req    = r_dm_req;
  assign dm_we     = r_dm_we;
  assign dm_addr   = r_dm_addr;
  assign dm_wdata  = r_dm_wdata;
  assign wb_regW   = r_wb_regW;
  assign wb_gprDes = r_wb_gprDes;
  assign wb_data   = r_wb_data;
  assign bus_err   = r_bus_err;
endmodule
